// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin front end sharing one combinational ALU
// among NREQ requesters. Accept in IDLE, one EXEC cycle, held response.
// Optional build macro ALU_ARB_OPCHECK_EN adds rsp_err and lets undefined
// ALU codes (> 4'b0101) bypass EXEC with a fixed error response.
module alu_share_arbiter #(
  parameter int unsigned NREQ  = 2,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ*4-1:0]     req_ctrl,
  output logic [WIDTH-1:0]      alu_a,
  output logic [WIDTH-1:0]      alu_b,
  output logic [3:0]            alu_ctrl,
  input  logic [WIDTH-1:0]      alu_result,
  input  logic                  alu_zero,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_result,
  output logic                  rsp_zero,
`ifdef ALU_ARB_OPCHECK_EN
  output logic                  rsp_err,
`endif
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state, next_state;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   id_q;
  logic [IDW-1:0]   win;
  logic [IDW-1:0]   cand;
  logic             any_req;
  logic             accept;
  logic [WIDTH-1:0] a_q, b_q;
  logic [3:0]       ctrl_q;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic [3:0]       sel_ctrl;
`ifdef ALU_ARB_OPCHECK_EN
  logic             illegal;
`endif

  // Round-robin search starting one past the last winner, wrapping at NREQ-1.
  always_comb begin
    any_req = 1'b0;
    win     = '0;
    cand    = rr_ptr;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = (cand == IDW'(NREQ - 1)) ? '0 : cand + 1'b1;
      if (!any_req && req_valid[cand]) begin
        any_req = 1'b1;
        win     = cand;
      end
    end
  end

  // Select the winner's operand slices.
  always_comb begin
    sel_a    = '0;
    sel_b    = '0;
    sel_ctrl = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (win == IDW'(i)) begin
        sel_a    = req_a[i*WIDTH +: WIDTH];
        sel_b    = req_b[i*WIDTH +: WIDTH];
        sel_ctrl = req_ctrl[i*4 +: 4];
      end
    end
  end

`ifdef ALU_ARB_OPCHECK_EN
  assign illegal = (sel_ctrl > 4'b0101);
`endif

  assign accept    = (state == IDLE) && any_req;
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_ctrl  = ctrl_q;
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

  // One-hot accept strobe, only offered while idle.
  always_comb begin
    req_ready = '0;
    if (accept) req_ready[win] = 1'b1;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (any_req) begin
`ifdef ALU_ARB_OPCHECK_EN
          next_state = illegal ? RESP : EXEC;
`else
          next_state = EXEC;
`endif
        end
      end
      EXEC:    next_state = RESP;
      RESP:    if (rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Operand latching, round-robin pointer and response capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr     <= IDW'(NREQ - 1);
      id_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      ctrl_q     <= '0;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
`ifdef ALU_ARB_OPCHECK_EN
      rsp_err    <= 1'b0;
`endif
    end else begin
      if (accept) begin
        rr_ptr <= win;
        id_q   <= win;
`ifdef ALU_ARB_OPCHECK_EN
        if (illegal) begin
          // Undefined code: respond directly, ALU operands left untouched.
          rsp_id     <= win;
          rsp_result <= '0;
          rsp_zero   <= 1'b1;
          rsp_err    <= 1'b1;
        end else begin
          a_q    <= sel_a;
          b_q    <= sel_b;
          ctrl_q <= sel_ctrl;
        end
`else
        a_q    <= sel_a;
        b_q    <= sel_b;
        ctrl_q <= sel_ctrl;
`endif
      end
      if (state == EXEC) begin
        rsp_result <= alu_result;
        rsp_zero   <= alu_zero;
        rsp_id     <= id_q;
`ifdef ALU_ARB_OPCHECK_EN
        rsp_err    <= 1'b0;
`endif
      end
    end
  end

endmodule
